axil_read_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI-Lite read channel (slave side, e.g. `axi_lite_slave_read` or a register block) among `NUM_MASTERS` AXI-Lite read masters. It accepts one address from the winning master, forwards it downstream, and routes the single read response back to that master. Only one transaction is outstanding at a time. It sits between the masters and the shared read slave in the peripheral interconnect.

---
 rtl/axil_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_axil_read_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read slave among NUM_MASTERS read masters.
// One transaction in flight; AR path registered, R path combinational in DATA.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; rotating search offers ARREADY to one master
// ADDR    | latched address presented downstream, waiting for ARREADY
// DATA    | downstream R channel routed to the granted master
module axil_read_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                          S_AXIL_ACLK,
    input  logic                          S_AXIL_ARESETn,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_ARVALID,
    output logic [NUM_MASTERS-1:0]        S_AXIL_ARREADY,
    input  logic [NUM_MASTERS*ADDR_W-1:0] S_AXIL_ARADDR,
    input  logic [NUM_MASTERS*3-1:0]      S_AXIL_ARPROT,
    output logic [NUM_MASTERS-1:0]        S_AXIL_RVALID,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_RREADY,
    output logic [DATA_W-1:0]             S_AXIL_RDATA,
    output logic [1:0]                    S_AXIL_RRESP,
    output logic                          M_AXIL_ARVALID,
    input  logic                          M_AXIL_ARREADY,
    output logic [ADDR_W-1:0]             M_AXIL_ARADDR,
    output logic [2:0]                    M_AXIL_ARPROT,
    input  logic                          M_AXIL_RVALID,
    output logic                          M_AXIL_RREADY,
    input  logic [DATA_W-1:0]             M_AXIL_RDATA,
    input  logic [1:0]                    M_AXIL_RRESP,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  araddr_q;
    logic [2:0]         arprot_q;
    logic               arvalid_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [2:0]         win_prot;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_MASTERS);
            if (!win_found && S_AXIL_ARVALID[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_prot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_addr = S_AXIL_ARADDR[i*ADDR_W +: ADDR_W];
                win_prot = S_AXIL_ARPROT[i*3 +: 3];
            end
        end
    end

    always_comb begin
        S_AXIL_ARREADY = '0;
        S_AXIL_RVALID  = '0;
        M_AXIL_RREADY  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) S_AXIL_ARREADY[win_idx] = 1'b1;
            end
            ST_DATA: begin
                S_AXIL_RVALID[grant_q] = M_AXIL_RVALID;
                M_AXIL_RREADY          = S_AXIL_RREADY[grant_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
        if (!S_AXIL_ARESETn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
            grant_q      <= '0;
            araddr_q     <= '0;
            arprot_q     <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_q      <= win_idx;
                        last_grant_q <= win_idx;
                        araddr_q     <= win_addr;
                        arprot_q     <= win_prot;
                        arvalid_q    <= 1'b1;
                        state_q      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M_AXIL_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (M_AXIL_RVALID && S_AXIL_RREADY[grant_q]) state_q <= ST_IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AXIL_ARVALID = arvalid_q;
    assign M_AXIL_ARADDR  = araddr_q;
    assign M_AXIL_ARPROT  = arprot_q;
    assign S_AXIL_RDATA   = M_AXIL_RDATA;
    assign S_AXIL_RRESP   = M_AXIL_RRESP;
    assign grant_idx      = grant_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Bench for axil_read_arbiter: master/slave agents, transaction-level reference model
// and scoreboard queues checked by a negedge monitor.
module tb_axil_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_araddr;
    logic [N*3-1:0]  s_arprot;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    axil_read_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .S_AXIL_ACLK(clk), .S_AXIL_ARESETn(rst_n),
        .S_AXIL_ARVALID(s_arvalid), .S_AXIL_ARREADY(s_arready),
        .S_AXIL_ARADDR(s_araddr), .S_AXIL_ARPROT(s_arprot),
        .S_AXIL_RVALID(s_rvalid), .S_AXIL_RREADY(s_rready),
        .S_AXIL_RDATA(s_rdata), .S_AXIL_RRESP(s_rresp),
        .M_AXIL_ARVALID(m_arvalid), .M_AXIL_ARREADY(m_arready),
        .M_AXIL_ARADDR(m_araddr), .M_AXIL_ARPROT(m_arprot),
        .M_AXIL_RVALID(m_rvalid), .M_AXIL_RREADY(m_rready),
        .M_AXIL_RDATA(m_rdata), .M_AXIL_RRESP(m_rresp),
        .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } ar_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; } r_t;

    ar_t           req_q  [N][$];
    ar_t           exp_ar [N][$];
    r_t            exp_r_q[$];
    logic [AW-1:0] dn_addr_log[$];
    int            arv_len_log[$];
    int            rstall_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: one outstanding transaction at most
    bit out_valid = 0, addr_sent = 0;
    int out_m = 0, m_last = N - 1, m_gidx = 0, mw;
    logic [N-1:0] m_ea, m_er;
    logic m_emr;
    int arv_cnt = 0, rs_cnt = 0;
    logic [DW-1:0] last_rdata = '0;
    logic [1:0]    last_rresp = '0;
    r_t            mon_r;

    // handshake flags sampled at negedge, consumed by the agents after the next posedge
    logic [N-1:0] up_hs = '0, rv_seen = '0;
    bit dn_ar_hs = 0, dn_r_hs = 0, mar_seen = 0;

    // agent knobs
    int ar_prob = 100, ar_stall = 0, rd_delay_max = 0, rr_prob = 100, rr_stall = 0;
    bit force_data = 0, force_resp = 0;
    logic [DW-1:0] f_data = '0;
    logic [1:0]    f_resp = '0;
    bit s_pend = 0;
    int s_delay = 0, ar_cnt = 0;
    int rr_cnt[N];
    int rm, cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic issue(input int m, input logic [AW-1:0] a, input logic [2:0] p);
        ar_t t;
        t.addr = a;
        t.prot = p;
        req_q[m].push_back(t);
        exp_ar[m].push_back(t);
    endtask

    function automatic bit pending();
        bit b = out_valid || s_pend || m_rvalid;
        for (int i = 0; i < N; i++) if (req_q[i].size() != 0) b = 1;
        return b;
    endfunction

    task automatic drain(input int budget, input string name);
        int c = 0;
        while (pending() && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        if (c >= budget) fail(name, "timed out waiting for transactions to complete");
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            req_q[i].delete();
            exp_ar[i].delete();
        end
        exp_r_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // master agents
    initial forever begin
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                s_arvalid[i] = 1'b0;
                s_rready[i]  = 1'b0;
                rr_cnt[i]    = 0;
            end else begin
                if (up_hs[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
                if (req_q[i].size() > 0) begin
                    s_arvalid[i]           = 1'b1;
                    s_araddr[i*AW +: AW]   = req_q[i][0].addr;
                    s_arprot[i*3 +: 3]     = req_q[i][0].prot;
                end else begin
                    s_arvalid[i] = 1'b0;
                end
                if (rv_seen[i] && s_rready[i]) rr_cnt[i] = 0;
                else if (rv_seen[i]) rr_cnt[i]++;
                s_rready[i] = (rr_cnt[i] >= rr_stall) && ($urandom_range(99) < rr_prob);
            end
        end
    end

    // downstream slave agent
    initial forever begin
        r_t r;
        @(posedge clk); #1;
        if (!rst_n) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            s_pend    = 0;
            ar_cnt    = 0;
        end else begin
            if (dn_r_hs) m_rvalid = 1'b0;
            if (dn_ar_hs) begin
                s_pend  = 1;
                s_delay = $urandom_range(rd_delay_max);
                ar_cnt  = 0;
            end else if (mar_seen) begin
                ar_cnt++;
            end
            m_arready = (ar_cnt >= ar_stall) && ($urandom_range(99) < ar_prob);
            if (s_pend && !m_rvalid) begin
                if (s_delay > 0) s_delay--;
                else begin
                    r.data   = force_data ? f_data : DW'($urandom());
                    r.resp   = force_resp ? f_resp : 2'($urandom_range(3));
                    m_rvalid = 1'b1;
                    m_rdata  = r.data;
                    m_rresp  = r.resp;
                    exp_r_q.push_back(r);
                    s_pend = 0;
                end
            end
        end
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_s_arready", 64'(s_arready), 64'(0));
            chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
            chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
            chk("rst_m_araddr", 64'(m_araddr), 64'(0));
            chk("rst_m_arprot", 64'(m_arprot), 64'(0));
            chk("rst_m_rready", 64'(m_rready), 64'(0));
            chk("rst_grant_idx", 64'(grant_idx), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            out_valid = 0; addr_sent = 0; m_last = N - 1; m_gidx = 0;
            arv_cnt = 0; rs_cnt = 0;
            up_hs = '0; rv_seen = '0; dn_ar_hs = 0; dn_r_hs = 0; mar_seen = 0;
        end else begin
            up_hs    = s_arvalid & s_arready;
            dn_ar_hs = m_arvalid && m_arready;
            dn_r_hs  = m_rvalid && m_rready;
            mar_seen = m_arvalid;
            rv_seen  = s_rvalid;

            m_ea = '0; m_er = '0; m_emr = 1'b0; mw = -1;
            if (!out_valid) begin
                mw = rr_pick(s_arvalid, m_last);
                if (mw >= 0) m_ea = ONE << mw;
            end else if (addr_sent) begin
                if (m_rvalid) m_er = ONE << out_m;
                m_emr = s_rready[out_m];
            end
            chk("s_arready", 64'(s_arready), 64'(m_ea));
            chk("s_rvalid", 64'(s_rvalid), 64'(m_er));
            chk("m_rready", 64'(m_rready), 64'(m_emr));
            chk("busy", 64'(busy), 64'(out_valid));
            chk("m_arvalid", 64'(m_arvalid), 64'(out_valid && !addr_sent));
            chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
            if (out_valid && !addr_sent) begin
                if (exp_ar[out_m].size() == 0) fail("ar_scoreboard", "address phase with no expected request");
                else begin
                    chk("m_araddr", 64'(m_araddr), 64'(exp_ar[out_m][0].addr));
                    chk("m_arprot", 64'(m_arprot), 64'(exp_ar[out_m][0].prot));
                end
            end
            if (m_arvalid) arv_cnt++;
            if (m_rvalid && !m_rready) rs_cnt++;

            if (!out_valid) begin
                if (mw >= 0) begin
                    out_valid = 1; addr_sent = 0;
                    out_m = mw; m_last = mw; m_gidx = mw;
                end
            end else if (!addr_sent) begin
                if (m_arready) begin
                    if (exp_ar[out_m].size() > 0) void'(exp_ar[out_m].pop_front());
                    dn_addr_log.push_back(m_araddr);
                    arv_len_log.push_back(arv_cnt);
                    arv_cnt = 0;
                    addr_sent = 1;
                end
            end else if (m_rvalid && s_rready[out_m]) begin
                if (exp_r_q.size() == 0) fail("r_scoreboard", "read handshake with no expected response");
                else begin
                    mon_r = exp_r_q.pop_front();
                    chk("s_rdata", 64'(s_rdata), 64'(mon_r.data));
                    chk("s_rresp", 64'(s_rresp), 64'(mon_r.resp));
                end
                last_rdata = s_rdata;
                last_rresp = s_rresp;
                rstall_log.push_back(rs_cnt);
                rs_cnt = 0;
                out_valid = 0;
            end
        end
    end

    initial begin
        #500000;
        fail("watchdog", "simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arprot = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        for (int i = 0; i < N; i++) rr_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single request from master 2
        force_data = 1; f_data = 32'hDEAD_BEEF; force_resp = 1; f_resp = 2'b00;
        dn_addr_log.delete();
        issue(2, 32'h0000_0040, 3'd0);
        drain(100, "single_drain");
        if (dn_addr_log.size() != 1) fail("single_addr_count", "wrong number of downstream addresses");
        else chk("single_addr", 64'(dn_addr_log[0]), 64'h40);
        chk("single_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
        chk("single_grant_idx", 64'(grant_idx), 64'd2);

        // round-robin with all masters requesting
        do_reset();
        force_data = 0; force_resp = 0;
        dn_addr_log.delete();
        issue(0, 32'h00, 3'd0); issue(1, 32'h10, 3'd1); issue(2, 32'h20, 3'd2);
        issue(3, 32'h30, 3'd3); issue(0, 32'h00, 3'd4);
        drain(200, "rr_drain");
        chk("rr_count", 64'(dn_addr_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < dn_addr_log.size()) chk($sformatf("rr_order_%0d", i), 64'(dn_addr_log[i]), 64'((i % 4) * 16));

        // backpressure on both channels
        ar_stall = 5; rr_stall = 3;
        arv_len_log.delete(); rstall_log.delete();
        issue(1, 32'h100, 3'd2); issue(3, 32'h300, 3'd5);
        drain(300, "bp_drain");
        chk("bp_ar_count", 64'(arv_len_log.size()), 64'd2);
        chk("bp_r_count", 64'(rstall_log.size()), 64'd2);
        foreach (arv_len_log[i]) chk("bp_arvalid_cycles", 64'(arv_len_log[i]), 64'd6);
        foreach (rstall_log[i]) chk("bp_rready_low_cycles", 64'(rstall_log[i]), 64'd3);
        ar_stall = 0; rr_stall = 0;

        // SLVERR pass-through
        force_resp = 1; f_resp = 2'b10;
        issue(2, 32'h80, 3'd0);
        drain(100, "err_drain");
        chk("err_rresp", 64'(last_rresp), 64'h2);
        force_resp = 0;

        // reset while the address is pending downstream
        ar_stall = 1000;
        issue(1, 32'h55, 3'd1);
        cyc = 0;
        while (!m_arvalid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("pre_rst_arvalid", 64'(m_arvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("async_rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        clear_all();
        ar_stall = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dn_addr_log.delete();
        issue(3, 32'h333, 3'd0); issue(0, 32'h000, 3'd0);
        drain(100, "post_rst_drain");
        chk("post_rst_count", 64'(dn_addr_log.size()), 64'd2);
        if (dn_addr_log.size() == 2) begin
            chk("post_rst_first", 64'(dn_addr_log[0]), 64'h000);
            chk("post_rst_second", 64'(dn_addr_log[1]), 64'h333);
        end

        // randomized traffic with random stalls and responses
        ar_prob = 60; rr_prob = 60; rd_delay_max = 3;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #3;
            if ($urandom_range(99) < 40) begin
                rm = $urandom_range(N - 1);
                if (req_q[rm].size() < 3) issue(rm, AW'($urandom()), 3'($urandom_range(7)));
            end
        end
        drain(5000, "random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
